// File: rtl/ac97_frame_rx.sv
// ac97_frame_rx: AC-link receive deframer. Aligns to SYNC, decodes TAG, status slots 1/2 and
// capture slots 3/4, and buffers capture samples in a first-word-fall-through FIFO.
module ac97_frame_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int PCM_W      = 20
) (
    input  logic             ac97_bitclk,
    input  logic             ac97_rst_b,
    input  logic             ac97_sync,
    input  logic             ac97_sdata_in,
    output logic             codec_ready,
    output logic [6:0]       status_addr,
    output logic [15:0]      status_data,
    output logic             status_valid,
    output logic [PCM_W-1:0] pcm_left,
    output logic [PCM_W-1:0] pcm_right,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             overflow,
    output logic             frame_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {HUNT, RECV} state_e;

    state_e           state_q;
    logic [7:0]       bitcnt_q;
    logic [95:0]      shift_q;
    logic             sync_q;
    logic             commit_q;
    logic             frame_err_q;
    logic             codec_ready_q;
    logic [6:0]       status_addr_q;
    logic [15:0]      status_data_q;
    logic             status_valid_q;
    logic [PCM_W-1:0] mem_l [FIFO_DEPTH];
    logic [PCM_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic             sync_rise;
    logic             push_d;
    logic             pop_d;
    logic             full_d;
    logic             accept_d;
    logic [PCM_W-1:0] left_d;
    logic [PCM_W-1:0] right_d;

    assign sync_rise = ac97_sync & ~sync_q;

    // SYNC history runs through reset, so a level already high at release is not taken as a rise.
    always_ff @(posedge ac97_bitclk) begin
        sync_q <= ac97_sync;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ac97_bitclk) begin
        if (!ac97_rst_b) begin
            state_q     <= HUNT;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (sync_rise) begin
                        state_q  <= RECV;
                        bitcnt_q <= '0;
                    end
                end
                RECV: begin
                    if (bitcnt_q < 8'd96) begin
                        shift_q <= {shift_q[94:0], ac97_sdata_in};
                    end
                    if (bitcnt_q == 8'd255) begin
                        bitcnt_q <= '0;
                        if (sync_rise) begin
                            commit_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= HUNT;
                        end
                    end else if (sync_rise) begin
                        frame_err_q <= 1'b1;
                        bitcnt_q    <= '0;
                    end else begin
                        bitcnt_q <= bitcnt_q + 8'd1;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    // Frame bit i sits in shift_q[95-i]; the register is still intact during the commit cycle.
    assign push_d   = commit_q & shift_q[95] & (shift_q[92] | shift_q[91]);
    assign pop_d    = (count_q != '0) & pcm_ready;
    assign full_d   = (count_q == CNT_W'(FIFO_DEPTH));
    assign accept_d = push_d & (~full_d | pop_d);
    assign left_d   = shift_q[92] ? shift_q[39 -: PCM_W] : '0;
    assign right_d  = shift_q[91] ? shift_q[19 -: PCM_W] : '0;

    always_ff @(posedge ac97_bitclk) begin
        if (!ac97_rst_b) begin
            codec_ready_q  <= 1'b0;
            status_addr_q  <= '0;
            status_data_q  <= '0;
            status_valid_q <= 1'b0;
        end else begin
            status_valid_q <= 1'b0;
            if (commit_q) begin
                codec_ready_q <= shift_q[95];
                if (shift_q[95] && shift_q[94] && shift_q[93]) begin
                    status_addr_q  <= shift_q[78:72];
                    status_data_q  <= shift_q[59:44];
                    status_valid_q <= 1'b1;
                end
            end
        end
    end

    // NOTE: FIFO storage is not reset; the count alone decides what is visible.
    always_ff @(posedge ac97_bitclk) begin
        if (accept_d) begin
            mem_l[wr_ptr_q] <= left_d;
            mem_r[wr_ptr_q] <= right_d;
        end
    end

    always_ff @(posedge ac97_bitclk) begin
        if (!ac97_rst_b) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept_d) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_d)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({accept_d, pop_d})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (push_d && full_d && !pop_d) overflow_q <= 1'b1;
        end
    end

    assign codec_ready  = codec_ready_q;
    assign status_addr  = status_addr_q;
    assign status_data  = status_data_q;
    assign status_valid = status_valid_q;
    assign pcm_valid    = (count_q != '0);
    assign pcm_left     = pcm_valid ? mem_l[rd_ptr_q] : '0;
    assign pcm_right    = pcm_valid ? mem_r[rd_ptr_q] : '0;
    assign overflow     = overflow_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ac97_frame_rx.sv
// tb_ac97_frame_rx: table-driven frame vectors, multi-cycle corner sequences and a randomized
// stream scored against a frame-level reference model of the deframer.
module tb_ac97_frame_rx;
    localparam int FIFO_DEPTH = 4;
    localparam int PCM_W      = 20;

    logic             clk = 1'b0;
    logic             ac97_rst_b;
    logic             ac97_sync;
    logic             ac97_sdata_in;
    logic             codec_ready;
    logic [6:0]       status_addr;
    logic [15:0]      status_data;
    logic             status_valid;
    logic [PCM_W-1:0] pcm_left;
    logic [PCM_W-1:0] pcm_right;
    logic             pcm_valid;
    logic             pcm_ready;
    logic             overflow;
    logic             frame_err;

    ac97_frame_rx #(.FIFO_DEPTH(FIFO_DEPTH), .PCM_W(PCM_W)) dut (
        .ac97_bitclk  (clk),
        .ac97_rst_b   (ac97_rst_b),
        .ac97_sync    (ac97_sync),
        .ac97_sdata_in(ac97_sdata_in),
        .codec_ready  (codec_ready),
        .status_addr  (status_addr),
        .status_data  (status_data),
        .status_valid (status_valid),
        .pcm_left     (pcm_left),
        .pcm_right    (pcm_right),
        .pcm_valid    (pcm_valid),
        .pcm_ready    (pcm_ready),
        .overflow     (overflow),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] tag;
        logic [19:0] s1, s2, s3, s4;
    } frame_t;

    typedef struct {
        frame_t      f;
        logic        ready;
        logic        sv;
        logic [6:0]  addr;
        logic [15:0] data;
        logic        pv;
        logic [19:0] l, r;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int n_err  = 0;
    int n_st   = 0;
    logic mon_en   = 1'b0;
    logic rand_rdy = 1'b0;
    logic last_ready = 1'b0;
    logic [22:0]        exp_st[$];
    logic [2*PCM_W-1:0] exp_pcm[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic frame_t mk(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                                  input logic [19:0] s3, input logic [19:0] s4);
        frame_t f;
        f.tag = tag; f.s1 = s1; f.s2 = s2; f.s3 = s3; f.s4 = s4;
        return f;
    endfunction

    function automatic logic [PCM_W-1:0] trunc(input logic [19:0] s);
        return PCM_W'(s >> (20 - PCM_W));
    endfunction

    // Reference model: effect of one correctly framed, uninterrupted frame.
    task automatic model_commit(input frame_t f);
        logic ready;
        ready = f.tag[15];
        if (ready && f.tag[14] && f.tag[13]) exp_st.push_back({f.s1[18:12], f.s2[19:4]});
        if (ready && (f.tag[12] || f.tag[11]))
            exp_pcm.push_back({f.tag[12] ? trunc(f.s3) : PCM_W'(0), f.tag[11] ? trunc(f.s4) : PCM_W'(0)});
        last_ready = ready;
    endtask

    task automatic cycle(input logic s, input logic d);
        ac97_sync     = s;
        ac97_sdata_in = d;
        if (rand_rdy) pcm_ready = 1'($urandom_range(0, 1));
        if (mon_en && pcm_valid && pcm_ready) begin
            if (exp_pcm.size() == 0) check("unexpected_pop", {pcm_left, pcm_right}, 64'hDEAD);
            else check("pcm_pair", {pcm_left, pcm_right}, exp_pcm.pop_front());
        end
        @(posedge clk);
        #1;
        if (frame_err) n_err++;
        if (status_valid) begin
            n_st++;
            if (mon_en) begin
                if (exp_st.size() == 0) check("unexpected_status", {status_addr, status_data}, 64'hDEAD);
                else check("status_pair", {status_addr, status_data}, exp_st.pop_front());
            end
        end
    endtask

    // Drives frame bits 0..255; rise_at<255 cuts the frame with an early SYNC rise, rst_at>=0
    // pulls reset low for two bits.
    task automatic send_frame(input frame_t f, input int rise_at, input int rst_at, input logic [159:0] fill);
        logic [255:0] v;
        logic         s;
        v = {f.tag, f.s1, f.s2, f.s3, f.s4, fill};
        for (int k = 0; k < 256; k++) begin
            if (k == 10) check("codec_ready_prev", codec_ready, last_ready);
            if (rst_at >= 0 && k == rst_at) begin
                ac97_rst_b = 1'b0;
                last_ready = 1'b0;
            end
            if (rst_at >= 0 && k == rst_at + 2) ac97_rst_b = 1'b1;
            s = (k <= 14) || (k == rise_at);
            cycle(s, v[255-k]);
            if (k == rise_at) break;
        end
        if (rise_at == 255 && rst_at < 0) model_commit(f);
    endtask

    task automatic apply_reset();
        ac97_rst_b = 1'b0;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        ac97_rst_b = 1'b1;
        exp_st.delete();
        exp_pcm.delete();
        last_ready = 1'b0;
        n_err = 0;
        n_st  = 0;
    endtask

    vec_t   tbl[7];
    frame_t f;

    initial begin
        tbl[0] = '{mk(16'h9800, 20'h0,     20'h0,     20'h12345, 20'hABCDE), 1, 0, 7'h00, 16'h0000, 1, 20'h12345, 20'hABCDE};
        tbl[1] = '{mk(16'hE000, 20'h26000, 20'h000F0, 20'h11111, 20'h22222), 1, 1, 7'h26, 16'h000F, 0, 20'h0,     20'h0};
        tbl[2] = '{mk(16'hF000, 20'h7F000, 20'hFFFF0, 20'h11111, 20'h22222), 1, 1, 7'h7F, 16'hFFFF, 1, 20'h11111, 20'h0};
        tbl[3] = '{mk(16'h7800, 20'h26000, 20'h000F0, 20'h33333, 20'h44444), 0, 0, 7'h00, 16'h0000, 0, 20'h0,     20'h0};
        tbl[4] = '{mk(16'h8800, 20'h0,     20'h0,     20'h55555, 20'h0F0F0), 1, 0, 7'h00, 16'h0000, 1, 20'h0,     20'h0F0F0};
        tbl[5] = '{mk(16'hC000, 20'h12000, 20'h12340, 20'h0,     20'h0),     1, 0, 7'h00, 16'h0000, 0, 20'h0,     20'h0};
        tbl[6] = '{mk(16'hE000, 20'h80FFF, 20'h0000F, 20'h0,     20'h0),     1, 1, 7'h00, 16'h0000, 0, 20'h0,     20'h0};

        ac97_rst_b = 1'b0; ac97_sync = 1'b0; ac97_sdata_in = 1'b0; pcm_ready = 1'b0;

        // Reset held with SYNC toggling: everything stays quiet.
        for (int i = 0; i < 4; i++) begin
            cycle(i[0], 1'($urandom_range(0, 1)));
            check("reset_flags", {codec_ready, status_valid, pcm_valid, overflow, frame_err}, 0);
            check("reset_data", {status_addr, status_data, pcm_left, pcm_right}, 0);
        end
        ac97_rst_b = 1'b1;
        cycle(1'b0, 1'b0);
        check("post_reset_flags", {codec_ready, status_valid, pcm_valid, overflow, frame_err}, 0);

        // Single aligned frames from the vector table.
        for (int i = 0; i < 7; i++) begin
            apply_reset();
            pcm_ready = 1'b1;
            cycle(1'b1, 1'b0);
            send_frame(tbl[i].f, 255, -1, '0);
            cycle(1'b1, 1'b0);
            check($sformatf("tbl%0d_ready", i), codec_ready, tbl[i].ready);
            check($sformatf("tbl%0d_sv", i), status_valid, tbl[i].sv);
            check($sformatf("tbl%0d_status", i), {status_addr, status_data}, {tbl[i].addr, tbl[i].data});
            check($sformatf("tbl%0d_pv", i), pcm_valid, tbl[i].pv);
            check($sformatf("tbl%0d_pcm", i), {pcm_left, pcm_right}, {tbl[i].l, tbl[i].r});
            cycle(1'b1, 1'b0);
            check($sformatf("tbl%0d_one_cycle", i), {status_valid, pcm_valid}, 0);
        end

        // Five captures into a four-entry FIFO with the consumer stalled.
        apply_reset();
        pcm_ready = 1'b0;
        cycle(1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) send_frame(mk(16'h9800, 20'h0, 20'h0, 20'(k), 20'hF0000 | 20'(k)), 255, -1, '0);
        check("no_overflow_at_4", overflow, 1'b0);
        cycle(1'b1, 1'b0);
        check("overflow_set", overflow, 1'b1);
        check("head_stable", pcm_left, 20'h1);
        pcm_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain%0d_valid", k), pcm_valid, 1'b1);
            check($sformatf("drain%0d_pcm", k), {pcm_left, pcm_right}, {20'(k), 20'hF0000 | 20'(k)});
            cycle(1'b1, 1'b0);
        end
        check("drained_empty", {pcm_valid, pcm_left}, 0);
        check("overflow_sticky", overflow, 1'b1);

        // Early SYNC rise at bit 100 discards the frame; the next aligned frame decodes.
        apply_reset();
        pcm_ready = 1'b1;
        mon_en = 1'b1;
        cycle(1'b1, 1'b0);
        send_frame(mk(16'hF800, 20'h35000, 20'hBEEF0, 20'h77777, 20'h88888), 100, -1, {5{$urandom()}});
        check("misalign_err", n_err, 1);
        check("misalign_no_update", {status_addr, status_data, pcm_valid, 32'(n_st)}, 0);
        send_frame(mk(16'hF800, 20'h35000, 20'hBEEF0, 20'hAAAAA, 20'h55555), 255, -1, {5{$urandom()}});
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        check("resync_consumed", exp_st.size() + exp_pcm.size(), 0);
        check("resync_counts", {32'(n_err), 32'(n_st)}, {32'd1, 32'd1});

        // Reset pulse at bit 50 of a capture frame.
        apply_reset();
        cycle(1'b1, 1'b0);
        send_frame(mk(16'h9800, 20'h0, 20'h0, 20'h24680, 20'h13579), 255, 50, '0);
        check("rst_mid_nothing", {pcm_valid, codec_ready}, 0);
        send_frame(mk(16'h9800, 20'h0, 20'h0, 20'h13579, 20'h2468A), 255, -1, '0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        check("rst_mid_consumed", exp_pcm.size(), 0);
        check("rst_mid_no_err", n_err, 0);
        check("rst_mid_ready", codec_ready, 1'b1);

        // Randomized back-to-back frames with a random consumer.
        apply_reset();
        rand_rdy = 1'b1;
        cycle(1'b1, 1'b0);
        for (int n = 0; n < 24; n++) begin
            f = mk(16'($urandom()), 20'($urandom()), 20'($urandom()), 20'($urandom()), 20'($urandom()));
            f.tag[15] = ($urandom_range(0, 3) != 0);
            send_frame(f, 255, -1, {5{$urandom()}});
        end
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 200 && exp_pcm.size() > 0; i++) cycle(1'b0, 1'b0);
        rand_rdy = 1'b0;
        check("rand_pcm_consumed", exp_pcm.size(), 0);
        check("rand_status_consumed", exp_st.size(), 0);
        check("rand_no_overflow", overflow, 1'b0);
        check("rand_no_err", n_err, 0);
        check("rand_ready", codec_ready, last_ready);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
